// File: rtl/sgm_disparity_select_pipe_pkg.sv
// Shared types, width derivations and latency helpers for the SGM disparity select pipeline.
// Optional second-minimum uniqueness check is enabled by defining SGM_UNIQUENESS_EN.
package sgm_pkg;

    typedef struct packed {
        logic de;
        logic h_sync;
        logic v_sync;
        logic mask;
    } pix_ctrl_t;

    localparam logic [7:0] INVALID_DISP_DEFAULT = 8'hFF;
    localparam int COL_BITS = 11;

`ifdef SGM_UNIQUENESS_EN
    localparam int UNIQ_STAGES = 1;
`else
    localparam int UNIQ_STAGES = 0;
`endif

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    function automatic int total_cost_bits(input int acc_bits, input int n_paths);
        return acc_bits + clog2(n_paths);
    endfunction

    function automatic int index_bits(input int disparity_range);
        return clog2(disparity_range);
    endfunction

    // Bit offset of path p, disparity d inside the packed L_arr bus.
    function automatic int larr_offset(input int path, input int disp,
                                       input int disparity_range, input int acc_bits);
        return (path * disparity_range + disp) * acc_bits;
    endfunction

    function automatic int sel_latency(input int disparity_range);
        return 2 + UNIQ_STAGES + clog2(disparity_range);
    endfunction

    localparam int SEL_LATENCY = sel_latency(32);

endpackage

// File: rtl/sgm_disparity_select_pipe_argmin_pipe_stage.sv
// One registered level of the argmin tree: pairwise (value, index) select, lower index wins ties.
// With SGM_UNIQUENESS_EN defined each node also carries the running second minimum.
module argmin_pipe_stage
    import sgm_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int VAL_BITS = 9,
    parameter int IDX_BITS = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_IN*VAL_BITS-1:0]      cand_val,
    input  logic [N_IN*IDX_BITS-1:0]      cand_idx,
`ifdef SGM_UNIQUENESS_EN
    input  logic [N_IN*VAL_BITS-1:0]      cand_sec,
    output logic [(N_IN/2)*VAL_BITS-1:0]  win_sec,
`endif
    input  pix_ctrl_t                     cand_ctrl,
    output logic [(N_IN/2)*VAL_BITS-1:0]  win_val,
    output logic [(N_IN/2)*IDX_BITS-1:0]  win_idx,
    output pix_ctrl_t                     win_ctrl
);

    localparam int N_OUT = N_IN / 2;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_ctrl <= '0;
        end else begin
            win_ctrl <= cand_ctrl;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_pair
            logic [VAL_BITS-1:0] a_val, b_val, val_reg;
            logic [IDX_BITS-1:0] a_idx, b_idx, idx_reg;
            logic                take_b;

            assign a_val  = cand_val[(2*gi)*VAL_BITS +: VAL_BITS];
            assign b_val  = cand_val[(2*gi+1)*VAL_BITS +: VAL_BITS];
            assign a_idx  = cand_idx[(2*gi)*IDX_BITS +: IDX_BITS];
            assign b_idx  = cand_idx[(2*gi+1)*IDX_BITS +: IDX_BITS];
            // Strict compare: the left (lower index) operand keeps equal costs.
            assign take_b = b_val < a_val;

            always_ff @(posedge clk) begin
                val_reg <= take_b ? b_val : a_val;
                idx_reg <= take_b ? b_idx : a_idx;
            end

            assign win_val[gi*VAL_BITS +: VAL_BITS] = val_reg;
            assign win_idx[gi*IDX_BITS +: IDX_BITS] = idx_reg;

`ifdef SGM_UNIQUENESS_EN
            logic [VAL_BITS-1:0] a_sec, b_sec, loser_val, winner_sec, sec_reg;

            assign a_sec      = cand_sec[(2*gi)*VAL_BITS +: VAL_BITS];
            assign b_sec      = cand_sec[(2*gi+1)*VAL_BITS +: VAL_BITS];
            assign loser_val  = take_b ? a_val : b_val;
            assign winner_sec = take_b ? b_sec : a_sec;

            always_ff @(posedge clk) begin
                sec_reg <= (loser_val < winner_sec) ? loser_val : winner_sec;
            end

            assign win_sec[gi*VAL_BITS +: VAL_BITS] = sec_reg;
`endif
        end
    endgenerate

endmodule

// File: rtl/sgm_disparity_select_pipe.sv
// Sums N_PATHS path-cost arrays per disparity and selects the argmin through a registered tree,
// masking left-border columns. Define SGM_UNIQUENESS_EN for the second-minimum rejection stage.
module sgm_disparity_select_pipe
    import sgm_pkg::*;
#(
    parameter int          DISPARITY_RANGE = 32,
    parameter int          N_PATHS         = 4,
    parameter int          ACC_COST_BITS   = 7,
    parameter logic [7:0]  INVALID_DISP    = INVALID_DISP_DEFAULT,
    parameter int          UNIQ_RATIO      = 2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              de_in,
    input  logic                                              h_sync_in,
    input  logic                                              v_sync_in,
    input  logic [N_PATHS*DISPARITY_RANGE*ACC_COST_BITS-1:0]  L_arr_in,
    output logic                                              de_out,
    output logic                                              h_sync_out,
    output logic                                              v_sync_out,
    output logic [7:0]                                        pixel_disparity,
    output logic [total_cost_bits(ACC_COST_BITS, N_PATHS)-1:0] min_cost_out,
    output logic                                              valid_out
);

    localparam int TCB = total_cost_bits(ACC_COST_BITS, N_PATHS);
    localparam int K   = clog2(DISPARITY_RANGE);
    localparam int IW  = index_bits(DISPARITY_RANGE);
    localparam bit CFG_OK = (DISPARITY_RANGE >= 4) && (DISPARITY_RANGE <= 128) &&
                            ((DISPARITY_RANGE & (DISPARITY_RANGE - 1)) == 0) &&
                            (N_PATHS >= 1) && (N_PATHS <= 8) &&
                            (UNIQ_RATIO >= 0) && (UNIQ_RATIO <= 15);

    // Column counter and border mask
    logic [COL_BITS-1:0] col_reg, col_next;
    logic                vs_prev_reg;
    pix_ctrl_t           in_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg     <= '0;
            vs_prev_reg <= 1'b0;
        end else begin
            col_reg     <= col_next;
            vs_prev_reg <= v_sync_in;
        end
    end

    always_comb begin
        col_next = col_reg;
        if (v_sync_in != vs_prev_reg) begin
            col_next = '0;
        end else if (de_in) begin
            col_next = (&col_reg) ? col_reg : col_reg + COL_BITS'(1);
        end else begin
            col_next = '0;
        end
    end

    always_comb begin
        in_ctrl.de     = de_in;
        in_ctrl.h_sync = h_sync_in;
        in_ctrl.v_sync = v_sync_in;
        in_ctrl.mask   = col_reg < COL_BITS'(DISPARITY_RANGE - 1);
    end

    // S0: input capture
    logic [N_PATHS*DISPARITY_RANGE*ACC_COST_BITS-1:0] larr_reg;
    pix_ctrl_t s0_ctrl_reg, s1_ctrl_reg;

    always_ff @(posedge clk) begin
        larr_reg <= L_arr_in;
        if (rst) begin
            s0_ctrl_reg <= '0;
            s1_ctrl_reg <= '0;
        end else begin
            s0_ctrl_reg <= in_ctrl;
            s1_ctrl_reg <= s0_ctrl_reg;
        end
    end

    // S1: full-precision per-disparity sums
    logic [DISPARITY_RANGE*TCB-1:0] sum_flat;

    genvar gi, gj;
    generate
        for (gi = 0; gi < DISPARITY_RANGE; gi++) begin : g_sum
            logic [TCB-1:0] acc, sum_reg;

            always_comb begin
                acc = '0;
                for (int p = 0; p < N_PATHS; p++) begin
                    acc = acc + TCB'(larr_reg[larr_offset(p, gi, DISPARITY_RANGE, ACC_COST_BITS) +: ACC_COST_BITS]);
                end
            end

            always_ff @(posedge clk) begin
                sum_reg <= acc;
            end

            assign sum_flat[gi*TCB +: TCB] = sum_reg;
        end

        // A1..AK: argmin tree, halving the candidate count per level
        for (gi = 0; gi < K; gi++) begin : g_lvl
            localparam int N_IN = DISPARITY_RANGE >> gi;

            logic [N_IN*TCB-1:0]     val_in;
            logic [N_IN*IW-1:0]      idx_in;
            pix_ctrl_t               ctrl_in, ctrl_out;
            logic [(N_IN/2)*TCB-1:0] val_out;
            logic [(N_IN/2)*IW-1:0]  idx_out;
`ifdef SGM_UNIQUENESS_EN
            logic [N_IN*TCB-1:0]     sec_in;
            logic [(N_IN/2)*TCB-1:0] sec_out;
`endif

            if (gi == 0) begin : g_first
                assign val_in  = sum_flat;
                assign ctrl_in = s1_ctrl_reg;
`ifdef SGM_UNIQUENESS_EN
                assign sec_in  = '1;
`endif
                for (gj = 0; gj < DISPARITY_RANGE; gj++) begin : g_idx
                    assign idx_in[gj*IW +: IW] = IW'(gj);
                end
            end else begin : g_rest
                assign val_in  = g_lvl[gi-1].val_out;
                assign idx_in  = g_lvl[gi-1].idx_out;
                assign ctrl_in = g_lvl[gi-1].ctrl_out;
`ifdef SGM_UNIQUENESS_EN
                assign sec_in  = g_lvl[gi-1].sec_out;
`endif
            end

            argmin_pipe_stage #(
                .N_IN     (N_IN),
                .VAL_BITS (TCB),
                .IDX_BITS (IW)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .cand_val  (val_in),
                .cand_idx  (idx_in),
`ifdef SGM_UNIQUENESS_EN
                .cand_sec  (sec_in),
                .win_sec   (sec_out),
`endif
                .cand_ctrl (ctrl_in),
                .win_val   (val_out),
                .win_idx   (idx_out),
                .win_ctrl  (ctrl_out)
            );
        end
    endgenerate

    logic [TCB-1:0] out_val;
    logic [IW-1:0]  out_idx;
    pix_ctrl_t      out_ctrl;
    logic           out_reject;

`ifdef SGM_UNIQUENESS_EN
    localparam int RW = TCB + 5;
    logic [RW-1:0]  lhs, rhs;
    logic [TCB-1:0] u_val_reg;
    logic [IW-1:0]  u_idx_reg;
    logic           u_reject_reg;
    pix_ctrl_t      u_ctrl_reg;

    // Ambiguous when the runner-up is within UNIQ_RATIO/16 of the winner.
    assign lhs = RW'(g_lvl[K-1].sec_out) << 4;
    assign rhs = RW'(g_lvl[K-1].val_out) * RW'(16 + UNIQ_RATIO);

    always_ff @(posedge clk) begin
        u_val_reg    <= g_lvl[K-1].val_out;
        u_idx_reg    <= g_lvl[K-1].idx_out;
        u_reject_reg <= lhs <= rhs;
        if (rst) begin
            u_ctrl_reg <= '0;
        end else begin
            u_ctrl_reg <= g_lvl[K-1].ctrl_out;
        end
    end

    assign out_val    = u_val_reg;
    assign out_idx    = u_idx_reg;
    assign out_ctrl   = u_ctrl_reg;
    assign out_reject = u_reject_reg;
`else
    assign out_val    = g_lvl[K-1].val_out;
    assign out_idx    = g_lvl[K-1].idx_out;
    assign out_ctrl   = g_lvl[K-1].ctrl_out;
    assign out_reject = 1'b0;
`endif

    // Outputs are forced quiet while reset is held; de=0 pixels carry no data.
    logic pix_shown;
    assign pix_shown = out_ctrl.de & ~rst;

    always_comb begin
        de_out          = pix_shown;
        h_sync_out      = out_ctrl.h_sync & ~rst;
        v_sync_out      = out_ctrl.v_sync & ~rst;
        pixel_disparity = 8'd0;
        min_cost_out    = '0;
        valid_out       = 1'b0;
        if (pix_shown) begin
            min_cost_out = out_val;
            if (out_ctrl.mask || out_reject) begin
                pixel_disparity = INVALID_DISP;
            end else begin
                pixel_disparity = 8'(out_idx);
                valid_out       = CFG_OK;
            end
        end
    end

endmodule

// File: tb/tb_sgm_disparity_select_pipe.sv
// Scoreboard bench for sgm_disparity_select_pipe (D=32, 4 paths, 7-bit costs).
// Honours SGM_UNIQUENESS_EN for the expected latency and rejection model.
module tb_sgm_disparity_select_pipe;

    localparam int D   = 32;
    localparam int NP  = 4;
    localparam int ACC = 7;
    localparam int TCB = 9;
`ifdef SGM_UNIQUENESS_EN
    localparam int L    = 8;
    localparam bit UNIQ = 1'b1;
`else
    localparam int L    = 7;
    localparam bit UNIQ = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              de_in, h_sync_in, v_sync_in;
    logic [NP*D*ACC-1:0] l_arr;
    logic              de_out, h_sync_out, v_sync_out, valid_out;
    logic [7:0]        pixel_disparity;
    logic [TCB-1:0]    min_cost_out;

    logic [ACC-1:0] cost [NP][D];

    typedef struct {
        logic           de;
        logic           hs;
        logic           vs;
        logic [7:0]     disp;
        logic [TCB-1:0] cst;
        logic           valid;
        bit             chk;
    } exp_t;

    exp_t sb[$];
    int   col_m;
    logic vsp_m;
    int   checks;
    int   errors;

    sgm_disparity_select_pipe #(
        .DISPARITY_RANGE (D),
        .N_PATHS         (NP),
        .ACC_COST_BITS   (ACC),
        .INVALID_DISP    (8'hFF),
        .UNIQ_RATIO      (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .de_in           (de_in),
        .h_sync_in       (h_sync_in),
        .v_sync_in       (v_sync_in),
        .L_arr_in        (l_arr),
        .de_out          (de_out),
        .h_sync_out      (h_sync_out),
        .v_sync_out      (v_sync_out),
        .pixel_disparity (pixel_disparity),
        .min_cost_out    (min_cost_out),
        .valid_out       (valid_out)
    );

    always #5 clk = ~clk;

    task automatic set_all(input int v);
        for (int p = 0; p < NP; p++)
            for (int d = 0; d < D; d++)
                cost[p][d] = ACC'(v);
    endtask

    // Drive one cycle, push its expected output, then compare the output due now.
    task automatic step(input string tag, input logic r, input logic d, input logic h,
                        input logic v, input bit chk);
        exp_t e, f, z;
        int   sums [D];
        int   best, bi, sec;
        bit   rej, mask;
        for (int dd = 0; dd < D; dd++) begin
            sums[dd] = 0;
            for (int p = 0; p < NP; p++) begin
                sums[dd] += int'(cost[p][dd]);
                l_arr[(p*D+dd)*ACC +: ACC] = cost[p][dd];
            end
        end
        best = sums[0];
        bi   = 0;
        sec  = 1 << 30;
        for (int dd = 1; dd < D; dd++) begin
            if (sums[dd] < best) begin
                sec  = best;
                best = sums[dd];
                bi   = dd;
            end else if (sums[dd] < sec) begin
                sec = sums[dd];
            end
        end
        rej  = UNIQ && (16 * sec <= 18 * best);
        mask = col_m < D - 1;
        e.de = d && !r;
        e.hs = h && !r;
        e.vs = v && !r;
        e.chk = chk;
        e.disp = 8'd0;
        e.cst = '0;
        e.valid = 1'b0;
        if (e.de) begin
            e.cst   = TCB'(best);
            e.disp  = (mask || rej) ? 8'hFF : 8'(bi);
            e.valid = !(mask || rej);
        end
        if (r) begin
            col_m = 0;
            vsp_m = 1'b0;
        end else begin
            if (v != vsp_m) col_m = 0;
            else if (d) col_m = (col_m == 2047) ? 2047 : col_m + 1;
            else col_m = 0;
            vsp_m = v;
        end

        rst = r;
        de_in = d;
        h_sync_in = h;
        v_sync_in = v;
        @(posedge clk);
        #1;

        sb.push_back(e);
        if (r) begin
            sb.delete();
            z.de = 1'b0; z.hs = 1'b0; z.vs = 1'b0; z.disp = 8'd0; z.cst = '0; z.valid = 1'b0; z.chk = 1'b1;
            for (int i = 0; i < L; i++) sb.push_back(z);
        end
        f = sb.pop_front();

        checks++;
        if (de_out !== f.de) begin
            errors++;
            $display("FAIL %s de_out got %b want %b", tag, de_out, f.de);
        end
        checks++;
        if (h_sync_out !== f.hs) begin
            errors++;
            $display("FAIL %s h_sync_out got %b want %b", tag, h_sync_out, f.hs);
        end
        checks++;
        if (v_sync_out !== f.vs) begin
            errors++;
            $display("FAIL %s v_sync_out got %b want %b", tag, v_sync_out, f.vs);
        end
        if (f.chk) begin
            checks++;
            if (pixel_disparity !== f.disp) begin
                errors++;
                $display("FAIL %s pixel_disparity got %h want %h", tag, pixel_disparity, f.disp);
            end
            checks++;
            if (min_cost_out !== f.cst) begin
                errors++;
                $display("FAIL %s min_cost_out got %0d want %0d", tag, min_cost_out, f.cst);
            end
            checks++;
            if (valid_out !== f.valid) begin
                errors++;
                $display("FAIL %s valid_out got %b want %b", tag, valid_out, f.valid);
            end
            if (f.de)
                $display("PIX %s disp %0d cost %0d valid %0b", tag, pixel_disparity, min_cost_out, valid_out);
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_line(input string tag, input int n, input logic h);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, h, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        set_all(0);
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle("reset_idle", L + 2);
    endtask

    task automatic test_single_min();
        set_all(20);
        for (int p = 0; p < NP; p++) cost[p][13] = 7'd4;
        run_line("single_min", 45, 1'b0);
        idle("single_min_flush", L);
    endtask

    task automatic test_tie();
        set_all(20);
        for (int p = 0; p < NP; p++) begin
            cost[p][5]  = 7'd4;
            cost[p][22] = 7'd4;
        end
        run_line("tie_5_22", 40, 1'b0);
        set_all(20);
        cost[0][9] = 7'd2; cost[1][9] = 7'd6; cost[2][9] = 7'd4; cost[3][9] = 7'd4;
        for (int p = 0; p < NP; p++) cost[p][30] = 7'd4;
        run_line("tie_9_30", 40, 1'b0);
        idle("tie_flush", L);
    endtask

    task automatic test_border();
        set_all(30);
        for (int p = 0; p < NP; p++) cost[p][3] = 7'd1;
        run_line("border_line1", 64, 1'b1);
        idle("border_gap", L + 3);
        run_line("border_line2", 40, 1'b1);
        idle("border_flush", L);
    endtask

    task automatic test_random_costs();
        for (int i = 0; i < 80; i++) begin
            for (int p = 0; p < NP; p++)
                for (int d = 0; d < D; d++)
                    cost[p][d] = ACC'($urandom_range(0, 127));
            step("rand_wide", 1'b0, 1'b1, 1'(i % 16 == 0), 1'b0, 1'b1);
        end
        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < NP; p++)
                for (int d = 0; d < D; d++)
                    cost[p][d] = ACC'($urandom_range(0, 3));
            step("rand_ties", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        idle("rand_flush", L);
    endtask

    task automatic test_uniqueness();
        set_all(30);
        for (int p = 0; p < NP; p++) cost[p][10] = 7'd8;
        cost[0][20] = 7'd8; cost[1][20] = 7'd9; cost[2][20] = 7'd9; cost[3][20] = 7'd9;
        run_line("uniq_35", 40, 1'b0);
        idle("uniq_gap", 2);
        cost[0][20] = 7'd9; cost[3][20] = 7'd10;
        run_line("uniq_37", 40, 1'b0);
        idle("uniq_gap", 2);
        set_all(25);
        run_line("uniq_flat", 40, 1'b0);
        idle("uniq_flush", L);
    endtask

    task automatic test_saturate();
        set_all(40);
        for (int p = 0; p < NP; p++) cost[p][17] = 7'd2;
        run_line("col_saturate", 2100, 1'b0);
        idle("col_saturate_flush", L);
    endtask

    task automatic test_sync();
        for (int i = 0; i < 1000; i++) begin
            for (int p = 0; p < NP; p++)
                for (int d = 0; d < D; d++)
                    cost[p][d] = ACC'($urandom_range(0, 127));
            step("sync_rand", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
        end
        idle("sync_flush", L + 2);
    endtask

    task automatic test_reset_mid_line();
        set_all(20);
        for (int p = 0; p < NP; p++) cost[p][6] = 7'd3;
        run_line("rst_mid_pre", 51, 1'b0);
        step("rst_mid_pulse", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle("rst_mid_quiet", L);
        run_line("rst_mid_post", 40, 1'b0);
        idle("rst_mid_flush", L);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        col_m = 0;
        vsp_m = 1'b0;
        rst = 1'b1;
        de_in = 1'b0;
        h_sync_in = 1'b0;
        v_sync_in = 1'b0;
        l_arr = '0;
        test_reset();
        test_single_min();
        test_tie();
        test_border();
        test_random_costs();
        test_uniqueness();
        test_saturate();
        test_sync();
        test_reset_mid_line();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sgm_disparity_select_pipe.md
Name: sgm_disparity_select_pipe

Overview:
Parametrised successor to the single-cycle combinational sum/argmin stage at the end of the SGM pipeline. It accepts N_PATHS packed path-cost arrays, sums them per disparity, and runs a registered argmin tree. The output carries synchronised de/h_sync/v_sync, and left-border pixels are masked as invalid. It sits between the path_cost_calculator instances and the video output, and makes path count, disparity range and pipeline depth generic.

Parameters:
DISPARITY_RANGE, 32, number of disparity levels D; must be a power of 2, from 4 to 128.
N_PATHS, 4, number of aggregated path-cost arrays; 1 to 8.
ACC_COST_BITS, 7, width of one path cost word.
INVALID_DISP, 8'hFF, disparity code emitted for masked or rejected pixels.
UNIQ_RATIO, 2, uniqueness margin in 1/16 units; used only with the optional feature.

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
de_in  in  1  data enable, aligned with L_arr_in
h_sync_in  in  1  horizontal sync
v_sync_in  in  1  vertical sync
L_arr_in  in  N_PATHS*D*ACC_COST_BITS  path costs; path p, disparity d at offset (p*D+d)*ACC_COST_BITS
de_out  out  1  delayed de
h_sync_out  out  1  delayed h_sync
v_sync_out  out  1  delayed v_sync
pixel_disparity  out  8  winning disparity, zero-extended, or INVALID_DISP
min_cost_out  out  TOTAL_COST_BITS  aggregated cost of the winner
valid_out  out  1  high when de_out=1 and the pixel is not masked or rejected

Behaviour:
- Reset is synchronous and active-high. While rst=1 or on the cycle after it, all outputs are 0; every pipeline valid/sync bit and the column counter are cleared.
- TOTAL_COST_BITS = ACC_COST_BITS + clog2(N_PATHS). Sums are full precision and never saturate.
- Stage S0 registers L_arr_in and the sync bits.
- Stage S1 registers the per-disparity sums S[d].
- Stages A1..A_K, with K = clog2(D), form the argmin tree. Each stage compares pairs of (value, index) and registers the winners.
- Tie rule: the lower index wins, i.e. the left operand of the pair on equality.
- Latency L = 2 + K clock cycles; 7 for D=32. Sync outputs equal the inputs delayed by exactly L cycles via a shift register.
- Column counter:
  - increments on each de_in=1 cycle;
  - clears to 0 on the first cycle with de_in=0 after de_in=1, and on any v_sync_in edge;
  - saturates at all-ones (11 bits) and does not wrap.
- Border mask: a pixel whose column is less than D-1 gets mask=1. The mask travels through the pipeline with the pixel.
- Output rule: if de_out=0, then pixel_disparity=0, min_cost_out=0 and valid_out=0. If de_out=1 and mask=1, then pixel_disparity=INVALID_DISP and valid_out=0; min_cost_out is still driven.
- The pipeline always advances. There is no back-pressure and no stall; de=0 bubbles pass through unchanged.
- Reset mid-frame: in-flight pixels are discarded, so no stale de_out appears after rst is released. The first valid output is the pixel presented L cycles after reset deasserts.

Optional Feature:
Macro SGM_UNIQUENESS_EN.
- Defined:
  - Each tree node also carries a second-minimum. Merge rule: second = min(loser.min, winner.second).
  - One extra registered stage, so L = 3 + K.
  - Reject when 16*second <= (16+UNIQ_RATIO)*min, computed at width TOTAL_COST_BITS+5. A rejected pixel outputs INVALID_DISP with valid_out=0.
  - With D where every other cost equals the minimum, the pixel is rejected.
- Undefined: no second-minimum logic, L = 2 + K, and no pixel is ever rejected for ambiguity.

Decomposition:
- Package sgm_pkg holds:
  - the clog2 function;
  - TOTAL_COST_BITS and the INDEX_BITS derivation;
  - the L_arr slicing offset helper;
  - the INVALID_DISP default;
  - the latency constant SEL_LATENCY, which is conditional on SGM_UNIQUENESS_EN.
- Sub-module argmin_pipe_stage: one tree level of registered pairwise compare/select. It is parametrised by input count, value width and index width, and carries the optional second-min, the mask and the sync bits.

Test Plan:
1. D=32, N_PATHS=4, all costs 20 except S[13]=4 on every path, de=1 from column 40 -> pixel_disparity=13, min_cost_out=16, valid_out=1, with exactly 7 cycles latency.
2. Tie: S[5]=S[22]=minimum -> pixel_disparity=5.
3. Border: line of 64 de cycles with winner 3 everywhere -> the first 31 outputs are 0xFF with valid_out=0, the following 33 outputs are 3 with valid_out=1; the counter resets on the next line.
4. Sync: random de/h_sync/v_sync pattern -> outputs equal the inputs delayed by L cycles, bit-exact, over 1000 cycles.
5. Reset mid-line: assert rst for 1 cycle at column 50 -> all outputs 0 on the following cycle; no de_out for L cycles; the column restarts at 0 on the next de run.
6. SGM_UNIQUENESS_EN, UNIQ_RATIO=2: min=32 with second=35 -> rejected (0xFF); min=32 with second=37 -> accepted; latency 8.
